// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: bundle of the channel inputs and display outputs for the
// seven-segment scan multiplexer.
//   ch_data    : NUM_CH*WIDTH flattened channel words, channel k at [k*WIDTH +: WIDTH]
//   ch_enable  : NUM_CH per-channel scan enables
//   mode       : 0 = auto-scan, 1 = manual select
//   man_sel    : SEL_W manual channel index
//   mux_out    : WIDTH registered selected word
//   digit_en_n : NUM_CH registered active-low one-hot digit enable
//   cur_sel    : SEL_W index of the currently selected channel
//   scan_tick  : one-clock pulse on every channel change
// master drives the channel inputs; slave is the multiplexer itself.
interface seg_scan_mux_if #(
  parameter int WIDTH  = 7,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_enable;
  logic                    mode;
  logic [SEL_W-1:0]        man_sel;
  logic [WIDTH-1:0]        mux_out;
  logic [NUM_CH-1:0]       digit_en_n;
  logic [SEL_W-1:0]        cur_sel;
  logic                    scan_tick;

  modport master (
    output ch_data, ch_enable, mode, man_sel,
    input  mux_out, digit_en_n, cur_sel, scan_tick
  );

  modport slave (
    input  ch_data, ch_enable, mode, man_sel,
    output mux_out, digit_en_n, cur_sel, scan_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-channel time multiplexer for the seven-segment display path.
// Scans NUM_CH words of WIDTH bits round-robin, DWELL clocks per channel,
// skipping disabled channels, with a manual-select mode.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_mux_if.slave (channel inputs, registered display outputs)
// Optional build macro BLANK_EN: every channel change inserts BLANK_CYCLES
// clocks of dark digits before the new channel is shown.
module seg_scan_mux #(
  parameter int WIDTH        = 7,
  parameter int NUM_CH       = 4,
  parameter int DWELL        = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DWELL);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("seg_scan_mux: NUM_CH must be at least 2");
  end
  if (DWELL < 2) begin : g_bad_dwell
    $error("seg_scan_mux: DWELL must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_scan_mux: BLANK_CYCLES must be at least 1");
  end

  typedef enum logic {SHOW, BLANK} state_t;

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel, sel_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              tick, tick_n;
  logic [WIDTH-1:0]  mux_q, mux_n;
  logic [NUM_CH-1:0] den_q, den_n;

  logic [SEL_W-1:0]  nxt;
  logic [SEL_W-1:0]  target;
  logic [WIDTH-1:0]  word;
  logic [NUM_CH-1:0] onehot_n;
  logic              any_en;
  logic              man_ok;
  logic              change;

`ifdef BLANK_EN
  localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);
  logic [BCNT_W-1:0] bcnt, bcnt_n;
`endif

  // Next enabled channel strictly above sel, wrapping. When sel itself is
  // disabled this is also the lowest enabled index at or above sel.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    nxt   = sel;
    found = 1'b0;
    for (int unsigned i = 1; i < NUM_CH; i++) begin
      idx = SEL_W'((32'(sel) + i) % NUM_CH);
      if (!found && bus.ch_enable[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    word     = '0;
    onehot_n = '1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        word        = bus.ch_data[k*WIDTH +: WIDTH];
        onehot_n[k] = 1'b0;
      end
    end
  end

  assign any_en = |bus.ch_enable;
  assign man_ok = (32'(bus.man_sel) < NUM_CH) && bus.ch_enable[bus.man_sel];

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    mux_n   = mux_q;
    den_n   = den_q;
    target  = sel;
    change  = 1'b0;
`ifdef BLANK_EN
    bcnt_n  = bcnt;
`endif
    case (state)
      SHOW: begin
        mux_n = word;
        den_n = onehot_n;
        // Priority: nothing enabled, valid manual pick, current channel
        // dropped, then manual hold / auto dwell expiry.
        if (!any_en) begin
          cnt_n = '0;
          mux_n = '0;
          den_n = '1;
        end else if (bus.mode && man_ok) begin
          cnt_n  = '0;
          target = bus.man_sel;
          change = (bus.man_sel != sel);
        end else if (!bus.ch_enable[sel]) begin
          cnt_n  = '0;
          target = nxt;
          change = 1'b1;
        end else if (bus.mode) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(DWELL - 1)) begin
          cnt_n  = '0;
          target = nxt;
          change = (nxt != sel);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        if (change) begin
          sel_n  = target;
          tick_n = 1'b1;
`ifdef BLANK_EN
          state_n = BLANK;
          bcnt_n  = '0;
`endif
        end
      end
`ifdef BLANK_EN
      BLANK: begin
        mux_n = '0;
        den_n = '1;
        if (bcnt == BCNT_W'(BLANK_CYCLES - 1)) begin
          state_n = SHOW;
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
`endif
      default: state_n = SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
      sel   <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
      mux_q <= '0;
      den_q <= '1;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      tick  <= tick_n;
      mux_q <= mux_n;
      den_q <= den_n;
    end
  end

`ifdef BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else begin
      bcnt <= bcnt_n;
    end
  end
`endif

  assign bus.mux_out    = mux_q;
  assign bus.digit_en_n = den_q;
  assign bus.cur_sel    = sel;
  assign bus.scan_tick  = tick;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed plus randomized stimulus for seg_scan_mux
// (WIDTH=7, NUM_CH=4, DWELL=4, BLANK_CYCLES=2) checked every clock against a
// behavioural reference model of the scan rules.
module tb_seg_scan_mux;
  localparam int W  = 7;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_mux_if #(.WIDTH(W), .NUM_CH(N)) bus ();

  seg_scan_mux #(
    .WIDTH(W),
    .NUM_CH(N),
    .DWELL(DW),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: selected channel, SHOW clocks spent on it,
  // remaining dark clocks, and the expected registered outputs.
  int m_sel, m_cnt, m_blank;
  int e_mux, e_den, e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_on(input int from, input logic [3:0] en);
    for (int d = 1; d <= N; d++) begin
      if (en[2'((from + d) % N)]) return (from + d) % N;
    end
    return from;
  endfunction

  function automatic int word_of(input int k);
    logic [27:0] cd;
    cd = bus.ch_data;
    return int'((cd >> (k * W)) & 28'h7F);
  endfunction

  task automatic model_reset();
    m_sel = 0; m_cnt = 0; m_blank = 0;
    e_mux = 0; e_den = 15; e_tick = 0;
  endtask

  task automatic model_edge();
    int nsel;
    e_tick = 0;
    if (m_blank > 0) begin
      e_mux = 0;
      e_den = 15;
      m_blank--;
    end else if (bus.ch_enable == 4'b0000) begin
      e_mux = 0;
      e_den = 15;
      m_cnt = 0;
    end else begin
      e_mux = word_of(m_sel);
      e_den = 15 - (1 << m_sel);
      nsel  = m_sel;
      if (bus.mode && bus.ch_enable[bus.man_sel]) begin
        nsel  = int'(bus.man_sel);
        m_cnt = 0;
      end else if (!bus.ch_enable[2'(m_sel)]) begin
        nsel  = next_on(m_sel, bus.ch_enable);
        m_cnt = 0;
      end else if (bus.mode) begin
        m_cnt = 0;
      end else if (m_cnt == DW - 1) begin
        nsel  = next_on(m_sel, bus.ch_enable);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (nsel != m_sel) begin
        m_sel  = nsel;
        e_tick = 1;
`ifdef BLANK_EN
        m_blank = BC;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mux_out",    32'(bus.mux_out),    32'(e_mux));
    chk("digit_en_n", 32'(bus.digit_en_n), 32'(e_den));
    chk("cur_sel",    32'(bus.cur_sel),    32'(m_sel));
    chk("scan_tick",  32'(bus.scan_tick),  32'(e_tick));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mux"},  32'(bus.mux_out),    32'h0);
    chk({tag, "_den"},  32'(bus.digit_en_n), 32'hF);
    chk({tag, "_sel"},  32'(bus.cur_sel),    32'h0);
    chk({tag, "_tick"}, 32'(bus.scan_tick),  32'h0);
  endtask

  initial begin
    bus.ch_data   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    bus.ch_enable = 4'b1111;
    bus.mode      = 1'b0;
    bus.man_sel   = 2'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst_init");
    rst_n = 1'b1;

    // Auto scan through all four channels and wrap
    run(18);

    // Reset asserted mid-dwell
    rst_n = 1'b0;
    #1;
    chk_reset_values("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_values("rst_edge");
    rst_n = 1'b1;
    run(9);

    // Skip disabled channels
    bus.ch_enable = 4'b1010;
    run(13);

    // Drop the current channel while it is selected
    for (int i = 0; i < 12 && bus.cur_sel != 2'd3; i++) step();
    chk("reach_sel3", 32'(bus.cur_sel), 32'd3);
    run(2);
    bus.ch_enable = 4'b0010;
    step();
    chk("drop3_sel",  32'(bus.cur_sel),   32'd1);
    chk("drop3_tick", 32'(bus.scan_tick), 32'd1);
    run(3);

    // Single enabled channel: no advance, no tick
    run(10);

    // All channels off, then re-enable one
    bus.ch_enable = 4'b0000;
    step();
    chk("off_den", 32'(bus.digit_en_n), 32'hF);
    chk("off_mux", 32'(bus.mux_out),    32'h0);
    run(4);
    bus.ch_enable = 4'b0100;
    run(4);

    // Manual mode
    bus.ch_enable = 4'b1111;
    bus.mode      = 1'b1;
    bus.man_sel   = 2'd0;
    run(4);
    bus.man_sel = 2'd2;
    step();
    chk("man_sel2", 32'(bus.cur_sel), 32'd2);
    run(6);
    bus.man_sel = 2'd0;
    run(4);
    bus.ch_enable = 4'b1011;
    bus.man_sel   = 2'd2;
    run(3);
    chk("man_dis_hold", 32'(bus.cur_sel), 32'd0);

    // Back to auto: four dwell clocks from channel 0, then channel 1
    bus.mode = 1'b0;
    run(3);
    chk("resume_hold", 32'(bus.cur_sel), 32'd0);
    step();
    chk("resume_adv", 32'(bus.cur_sel), 32'd1);

    // Data change on the selected channel shows one clock later
    run(2);
    bus.ch_data[13:7] = 7'h7F;
    step();
    chk("track_7f", 32'(bus.mux_out), 32'h7F);
    run(3);

    // Randomized stimulus
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.ch_enable = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 3) == 0) bus.man_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.ch_data = 28'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
